jt12_eg_slotmux: RTL and testbench
==================================

Name: jt12_eg_slotmux

Overview:
- Writer-side companion of the envelope generator.
- Holds the per-operator EG configuration and key-on state for all 24 operator slots, written by the CPU register decoder.
- Replays that configuration as a time-multiplexed slot stream, one slot per clk_en, with the slot-0 marker `zero`, feeding the EG's stage-II inputs.

Parameters:
- SLOTS, 24, number of operator slots in the rotation (6 channels x 4 operators).
- TL_RST, 7'h7F, reset value of total level (fully attenuated).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  slot-advance enable; the stream moves one slot per clk_en
- wr_en  in  1  parameter write strobe, sampled on any clk edge
- wr_slot  in  5  target slot 0..23 (slot = 6*op + ch)
- wr_reg  in  3  register group: 0=KS/AR, 1=AM/D1R, 2=D2R, 3=D1L/RR, 4=SSG-EG, 5=TL
- wr_data  in  8  register byte, chip bit layout
- wr_ack  out  1  one-clk pulse: write accepted
- wr_err  out  1  one-clk pulse: write rejected (bad slot or group)
- kon_wr  in  1  key-on write strobe
- kon_ch  in  3  channel 0..5
- kon_mask  in  4  bit k = key state of operator k of kon_ch
- zero  out  1  high while slot_out==0
- slot_out  out  5  slot the outputs currently describe
- keyon_II  out  1  key state
- arate_II  out  5  attack rate
- rate1_II  out  5  decay-1 rate
- rate2_II  out  5  decay-2 rate
- rrate_II  out  4  release rate
- d1l  out  4  sustain level
- ks  out  2  key scale
- ssg_en_II  out  1  SSG enable
- ssg_eg_II  out  3  SSG mode
- tl  out  7  total level
- amsen  out  1  AM enable

Behaviour:
- Reset (rst_n low, async):
  - Every storage entry and output is 0, except tl outputs and all stored TL, which are TL_RST.
  - slot counter is 0, so zero=1.
  - wr_ack=0, wr_err=0.
- Slot counter:
  - Advances only on clk edges where clk_en=1, counting 0..23 and wrapping to 0 after 23.
  - No clk_en means all outputs hold.
- Output latency:
  - On each clk_en edge all outputs are registered from storage[counter], and slot_out takes the counter value; the counter then increments.
  - Outputs therefore lag the counter by one clk_en.
  - zero is derived from the registered slot_out and is never combinational from inputs.
- Write decode (group: stored fields):
  - 0: ks=d[7:6], ar=d[4:0].
  - 1: amsen=d[7], d1r=d[4:0].
  - 2: d2r=d[4:0].
  - 3: d1l=d[7:4], rr=d[3:0].
  - 4: ssg_en=d[3], ssg_eg=d[2:0].
  - 5: tl=d[6:0].
  - Unused data bits are ignored.
- Write handshake:
  - A write is accepted in the same clk edge that samples wr_en=1, independent of clk_en; wr_ack pulses the following cycle.
  - wr_slot>23 or wr_reg>5: storage is unchanged and wr_err pulses instead of wr_ack.
  - Back-to-back writes are accepted every cycle.
- Key-on:
  - kon_wr=1 with kon_ch<=5 sets keyon[6*k+kon_ch]=kon_mask[k] for k=0..3, all four together in that edge.
  - kon_ch>5 is ignored; there is no ack.
- Simultaneous events:
  - Write and stream read of the same slot in the same edge: the output gets the old value (read-before-write); the new value appears on the next rotation.
  - wr_en and kon_wr in the same edge: both are applied.
  - Writes during clk_en=0 still update storage.
- Reset mid-rotation: the stream restarts at slot 0 on the first clk_en after rst_n rises. Stored values are lost.

Test Plan:
- Reset, then 24 clk_en pulses: zero high exactly once per 24, slot_out 0..23 in order, tl=7F, all rates 0.
- Write wr_slot=7, wr_reg=0, wr_data=8'hDF: wr_ack pulses once; when slot_out=7, ks=3 and arate_II=1F; other slots unchanged.
- kon_wr, kon_ch=2, kon_mask=4'b1010: keyon_II=1 only at slot_out 8 and 20; slots 2 and 14 are 0. Then kon_ch=6: no change.
- Write wr_reg=6 and wr_slot=24: wr_err pulses, no wr_ack, and all 24 slots read back unchanged.
- Write slot 5 group 3 (data 8'hA4) in the same edge that the stream reads slot 5: this rotation shows old d1l/rr (0/0); the next rotation shows d1l=A, rrate_II=4.
- Assert rst_n low mid-rotation at slot 13: outputs immediately take reset values. After release, the first clk_en gives slot_out=0 and zero=1.

Source files
------------

// File: rtl/jt12_eg_slotmux.sv
// Per-slot EG configuration/key-on store, replayed as a 24-slot stream advancing one slot per clk_en.
// Outputs lag the slot counter by one clk_en; writes never stall and are acked/rejected on the next clk.
module jt12_eg_slotmux #(
    parameter int         SLOTS  = 24,
    parameter logic [6:0] TL_RST = 7'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       wr_en,
    input  logic [4:0] wr_slot,
    input  logic [2:0] wr_reg,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    input  logic       kon_wr,
    input  logic [2:0] kon_ch,
    input  logic [3:0] kon_mask,
    output logic       zero,
    output logic [4:0] slot_out,
    output logic       keyon_II,
    output logic [4:0] arate_II,
    output logic [4:0] rate1_II,
    output logic [4:0] rate2_II,
    output logic [3:0] rrate_II,
    output logic [3:0] d1l,
    output logic [1:0] ks,
    output logic       ssg_en_II,
    output logic [2:0] ssg_eg_II,
    output logic [6:0] tl,
    output logic       amsen
);

    localparam logic [4:0] LAST = 5'(SLOTS - 1);

    logic [1:0] r_ks     [SLOTS];
    logic [4:0] r_ar     [SLOTS];
    logic       r_amsen  [SLOTS];
    logic [4:0] r_d1r    [SLOTS];
    logic [4:0] r_d2r    [SLOTS];
    logic [3:0] r_d1l    [SLOTS];
    logic [3:0] r_rr     [SLOTS];
    logic       r_ssg_en [SLOTS];
    logic [2:0] r_ssg_eg [SLOTS];
    logic [6:0] r_tl     [SLOTS];
    logic       r_keyon  [SLOTS];
    logic [4:0] r_cnt;

    logic       w_wr_ok;
    logic       w_kon_ok;
    logic [4:0] w_kon_idx [4];

    assign w_wr_ok  = (wr_slot <= LAST) && (wr_reg <= 3'd5);
    assign w_kon_ok = (kon_ch <= 3'd5);

    // Operator k of channel ch lives at slot 6*k + ch.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_kon_idx[k] = 5'(6 * k) + {2'b00, kon_ch};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_ks[i]     <= 2'd0;
                r_ar[i]     <= 5'd0;
                r_amsen[i]  <= 1'b0;
                r_d1r[i]    <= 5'd0;
                r_d2r[i]    <= 5'd0;
                r_d1l[i]    <= 4'd0;
                r_rr[i]     <= 4'd0;
                r_ssg_en[i] <= 1'b0;
                r_ssg_eg[i] <= 3'd0;
                r_tl[i]     <= TL_RST;
            end
        end else if (wr_en && w_wr_ok) begin
            case (wr_reg)
                3'd0: begin
                    r_ks[wr_slot] <= wr_data[7:6];
                    r_ar[wr_slot] <= wr_data[4:0];
                end
                3'd1: begin
                    r_amsen[wr_slot] <= wr_data[7];
                    r_d1r[wr_slot]   <= wr_data[4:0];
                end
                3'd2: r_d2r[wr_slot] <= wr_data[4:0];
                3'd3: begin
                    r_d1l[wr_slot] <= wr_data[7:4];
                    r_rr[wr_slot]  <= wr_data[3:0];
                end
                3'd4: begin
                    r_ssg_en[wr_slot] <= wr_data[3];
                    r_ssg_eg[wr_slot] <= wr_data[2:0];
                end
                3'd5: r_tl[wr_slot] <= wr_data[6:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_keyon[i] <= 1'b0;
            end
        end else if (kon_wr && w_kon_ok) begin
            for (int k = 0; k < 4; k++) begin
                r_keyon[w_kon_idx[k]] <= kon_mask[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_ack <= wr_en && w_wr_ok;
            wr_err <= wr_en && !w_wr_ok;
        end
    end

    // Reads sample storage before this edge's write lands, so a same-slot write shows next rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 5'd0;
            slot_out  <= 5'd0;
            keyon_II  <= 1'b0;
            arate_II  <= 5'd0;
            rate1_II  <= 5'd0;
            rate2_II  <= 5'd0;
            rrate_II  <= 4'd0;
            d1l       <= 4'd0;
            ks        <= 2'd0;
            ssg_en_II <= 1'b0;
            ssg_eg_II <= 3'd0;
            tl        <= TL_RST;
            amsen     <= 1'b0;
        end else if (clk_en) begin
            r_cnt     <= (r_cnt == LAST) ? 5'd0 : r_cnt + 5'd1;
            slot_out  <= r_cnt;
            keyon_II  <= r_keyon[r_cnt];
            arate_II  <= r_ar[r_cnt];
            rate1_II  <= r_d1r[r_cnt];
            rate2_II  <= r_d2r[r_cnt];
            rrate_II  <= r_rr[r_cnt];
            d1l       <= r_d1l[r_cnt];
            ks        <= r_ks[r_cnt];
            ssg_en_II <= r_ssg_en[r_cnt];
            ssg_eg_II <= r_ssg_eg[r_cnt];
            tl        <= r_tl[r_cnt];
            amsen     <= r_amsen[r_cnt];
        end
    end

    assign zero = (slot_out == 5'd0);

endmodule

// File: tb/tb_jt12_eg_slotmux.sv
// Bench for jt12_eg_slotmux: a behavioural slot store predicts each stream beat into a queue.
module tb_jt12_eg_slotmux;

    logic       clk, rst_n, clk_en;
    logic       wr_en;
    logic [4:0] wr_slot;
    logic [2:0] wr_reg;
    logic [7:0] wr_data;
    logic       wr_ack, wr_err;
    logic       kon_wr;
    logic [2:0] kon_ch;
    logic [3:0] kon_mask;
    logic       zero;
    logic [4:0] slot_out;
    logic       keyon_II;
    logic [4:0] arate_II, rate1_II, rate2_II;
    logic [3:0] rrate_II, d1l;
    logic [1:0] ks;
    logic       ssg_en_II;
    logic [2:0] ssg_eg_II;
    logic [6:0] tl;
    logic       amsen;

    jt12_eg_slotmux dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .wr_en(wr_en), .wr_slot(wr_slot), .wr_reg(wr_reg), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .kon_wr(kon_wr), .kon_ch(kon_ch), .kon_mask(kon_mask),
        .zero(zero), .slot_out(slot_out), .keyon_II(keyon_II),
        .arate_II(arate_II), .rate1_II(rate1_II), .rate2_II(rate2_II),
        .rrate_II(rrate_II), .d1l(d1l), .ks(ks),
        .ssg_en_II(ssg_en_II), .ssg_eg_II(ssg_eg_II), .tl(tl), .amsen(amsen)
    );

    typedef struct packed {
        logic [4:0] slot;
        logic       keyon;
        logic [4:0] ar;
        logic [4:0] d1r;
        logic [4:0] d2r;
        logic [3:0] rr;
        logic [3:0] d1l;
        logic [1:0] ks;
        logic       ssg_en;
        logic [2:0] ssg_eg;
        logic [6:0] tl;
        logic       amsen;
    } exp_t;

    logic [1:0] m_ks     [24];
    logic [4:0] m_ar     [24];
    logic       m_amsen  [24];
    logic [4:0] m_d1r    [24];
    logic [4:0] m_d2r    [24];
    logic [3:0] m_d1l    [24];
    logic [3:0] m_rr     [24];
    logic       m_ssg_en [24];
    logic [2:0] m_ssg_eg [24];
    logic [6:0] m_tl     [24];
    logic       m_keyon  [24];
    int         mcnt;
    exp_t       last_exp;
    exp_t       sbq [$];

    int errors = 0;
    int checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model_at(input int s);
        exp_t e;
        e.slot = 5'(s);   e.keyon = m_keyon[s]; e.ar = m_ar[s];   e.d1r = m_d1r[s];
        e.d2r = m_d2r[s]; e.rr = m_rr[s];       e.d1l = m_d1l[s]; e.ks = m_ks[s];
        e.ssg_en = m_ssg_en[s]; e.ssg_eg = m_ssg_eg[s]; e.tl = m_tl[s]; e.amsen = m_amsen[s];
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t e;
        e.slot = slot_out;  e.keyon = keyon_II; e.ar = arate_II; e.d1r = rate1_II;
        e.d2r = rate2_II;   e.rr = rrate_II;    e.d1l = d1l;     e.ks = ks;
        e.ssg_en = ssg_en_II; e.ssg_eg = ssg_eg_II; e.tl = tl;   e.amsen = amsen;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 24; i++) begin
            m_ks[i] = 0; m_ar[i] = 0; m_amsen[i] = 0; m_d1r[i] = 0; m_d2r[i] = 0;
            m_d1l[i] = 0; m_rr[i] = 0; m_ssg_en[i] = 0; m_ssg_eg[i] = 0;
            m_tl[i] = 7'h7F; m_keyon[i] = 0;
        end
        mcnt = 0;
        last_exp = '0;
        last_exp.tl = 7'h7F;
        sbq.delete();
    endtask

    task automatic model_apply();
        int s;
        s = int'(wr_slot);
        if (wr_en && wr_slot < 24 && wr_reg <= 5) begin
            case (wr_reg)
                3'd0: begin m_ks[s] = wr_data[7:6]; m_ar[s] = wr_data[4:0]; end
                3'd1: begin m_amsen[s] = wr_data[7]; m_d1r[s] = wr_data[4:0]; end
                3'd2: m_d2r[s] = wr_data[4:0];
                3'd3: begin m_d1l[s] = wr_data[7:4]; m_rr[s] = wr_data[3:0]; end
                3'd4: begin m_ssg_en[s] = wr_data[3]; m_ssg_eg[s] = wr_data[2:0]; end
                default: m_tl[s] = wr_data[6:0];
            endcase
        end
        if (kon_wr && kon_ch <= 5) begin
            for (int k = 0; k < 4; k++) m_keyon[6 * k + int'(kon_ch)] = kon_mask[k];
        end
    endtask

    // One clk cycle with the currently driven write/key-on inputs; checks handshake and stream.
    task automatic tick(input logic en);
        exp_t e;
        logic ea, ee;
        clk_en = en;
        if (en) sbq.push_back(model_at(mcnt));
        ea = wr_en && (wr_slot < 24) && (wr_reg <= 5);
        ee = wr_en && !((wr_slot < 24) && (wr_reg <= 5));
        @(posedge clk);
        model_apply();
        if (en) mcnt = (mcnt == 23) ? 0 : mcnt + 1;
        #1;
        wr_en = 0; kon_wr = 0; clk_en = 0;
        checks++;
        if (wr_ack !== ea) begin errors++; $display("FAIL wr_ack: got %b want %b", wr_ack, ea); end
        checks++;
        if (wr_err !== ee) begin errors++; $display("FAIL wr_err: got %b want %b", wr_err, ee); end
        if (en) begin
            e = sbq.pop_front();
            last_exp = e;
        end else begin
            e = last_exp;
        end
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL stream slot %0d: got %h want %h", e.slot, observed(), e);
        end
        checks++;
        if (zero !== (e.slot == 5'd0)) begin
            errors++; $display("FAIL zero: got %b at slot_out %0d", zero, slot_out);
        end
    endtask

    task automatic set_wr(input logic [4:0] s, input logic [2:0] r, input logic [7:0] d);
        wr_en = 1; wr_slot = s; wr_reg = r; wr_data = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        exp_t r;
        r = '0;
        r.tl = 7'h7F;
        checks++;
        if (observed() !== r || zero !== 1'b1 || wr_ack !== 1'b0 || wr_err !== 1'b0) begin
            errors++;
            $display("FAIL %s: got %h z=%b ack=%b err=%b want %h z=1 ack=0 err=0",
                     tag, observed(), zero, wr_ack, wr_err, r);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        model_reset();
        check_reset_outputs("reset_values");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rotation();
        int nzero;
        nzero = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            if (zero) nzero++;
        end
        checks++;
        if (nzero != 1) begin errors++; $display("FAIL zero_count: got %0d want 1", nzero); end
        tick(0);
        tick(0);
    endtask

    task automatic test_write();
        set_wr(5'd7, 3'd0, 8'hDF);
        tick(0);
        for (int i = 0; i < 24; i++) begin
            tick(1);
            if (slot_out == 5'd7) begin
                checks++;
                if (ks !== 2'd3 || arate_II !== 5'h1F) begin
                    errors++; $display("FAIL write_slot7: ks=%0d ar=%h want 3/1f", ks, arate_II);
                end
            end
        end
    endtask

    task automatic test_keyon();
        kon_wr = 1; kon_ch = 3'd2; kon_mask = 4'b1010;
        tick(0);
        for (int i = 0; i < 24; i++) begin
            tick(1);
            checks++;
            if (keyon_II !== (slot_out == 5'd8 || slot_out == 5'd20)) begin
                errors++; $display("FAIL keyon slot %0d: got %b", slot_out, keyon_II);
            end
        end
        kon_wr = 1; kon_ch = 3'd6; kon_mask = 4'b1111;
        tick(0);
        for (int i = 0; i < 24; i++) tick(1);
    endtask

    task automatic test_bad_write();
        set_wr(5'd3, 3'd6, 8'hFF);
        tick(0);
        set_wr(5'd24, 3'd0, 8'hFF);
        tick(1);
        set_wr(5'd31, 3'd5, 8'h00);
        tick(0);
        for (int i = 0; i < 24; i++) tick(1);
    endtask

    task automatic test_read_before_write();
        while (mcnt != 5) tick(1);
        set_wr(5'd5, 3'd3, 8'hA4);
        tick(1);
        checks++;
        if (slot_out !== 5'd5 || d1l !== 4'd0 || rrate_II !== 4'd0) begin
            errors++; $display("FAIL rbw_old: slot=%0d d1l=%h rr=%h want 5/0/0", slot_out, d1l, rrate_II);
        end
        for (int i = 0; i < 24; i++) tick(1);
        checks++;
        if (slot_out !== 5'd5 || d1l !== 4'hA || rrate_II !== 4'h4) begin
            errors++; $display("FAIL rbw_new: slot=%0d d1l=%h rr=%h want 5/a/4", slot_out, d1l, rrate_II);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            set_wr(5'($urandom_range(0, 23)), 3'(i % 6), 8'($urandom));
            if (i == 3) begin
                kon_wr = 1; kon_ch = 3'd5; kon_mask = 4'b0111;
            end
            tick(i[0]);
        end
        for (int i = 0; i < 30; i++) tick(1);
    endtask

    task automatic test_reset_mid();
        while (mcnt != 14) tick(1);
        checks++;
        if (slot_out !== 5'd13) begin errors++; $display("FAIL mid_slot: got %0d want 13", slot_out); end
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_reset_outputs("reset_mid");
        @(negedge clk);
        rst_n = 1;
        tick(0);
        tick(1);
        checks++;
        if (slot_out !== 5'd0 || zero !== 1'b1) begin
            errors++; $display("FAIL restart: slot=%0d zero=%b want 0/1", slot_out, zero);
        end
        for (int i = 0; i < 24; i++) tick(1);
    endtask

    initial begin
        rst_n = 1; clk_en = 0; wr_en = 0; wr_slot = 0; wr_reg = 0; wr_data = 0;
        kon_wr = 0; kon_ch = 0; kon_mask = 0;
        test_reset();
        test_rotation();
        test_write();
        test_keyon();
        test_bad_write();
        test_read_before_write();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
